// File: rtl/id_ex_elastic_reg.sv
// id_ex_elastic_reg: elastic ID/EX pipeline register.
// Carries an opaque payload from decode to execute through a DEPTH-entry buffer
// with a valid/ready handshake and hold, flush and bubble-insert controls.
// The output payload is zero whenever no valid entry is presented.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   decode presents a payload
//   in_ready_o   buffer accepts the payload this cycle
//   in_data_i    payload from decode
//   bubble_i     load-use stall, refuse the input this cycle
//   hold_i       busywait, freeze all state
//   flush_i      discard buffered and incoming payloads
//   out_valid_o  head entry valid
//   out_ready_i  execute consumes the head this cycle
//   out_data_o   head payload, zero when out_valid_o=0
//   count_o      occupancy, 0..DEPTH
module id_ex_elastic_reg #(
    parameter int unsigned DATA_W = 160,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              bubble_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    // Pointer advance with explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake derived from registered occupancy only; a full buffer does not
    // accept in the same cycle as a pop. Reset also forces ready low.
    assign in_ready_o  = (count < CNT_FULL) & ~hold_i & ~bubble_i & ~flush_i & ~rst_i;
    assign out_valid_o = (count != '0);
    assign out_data_o  = out_valid_o ? mem[rd_ptr] : '0;
    assign count_o     = count;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i & ~hold_i & ~flush_i;

    // Buffer state: reset clears storage, flush only rewinds pointers/count
    // (stale entries stay masked by out_valid_o). Hold is folded into push/pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data_i;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// tb_id_ex_elastic_reg: drives a DEPTH=2 and a DEPTH=3 instance with the same
// directed stimulus, checks both against a queue model every cycle and adds
// hand-computed literal expectations for the DEPTH=2 instance (and DEPTH=3
// for the bubble/wrap sequence).
module tb_id_ex_elastic_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        bubble;
    logic        hold;
    logic        flush;
    logic        out_ready;

    logic        in_ready2, out_valid2, in_ready3, out_valid3;
    logic [15:0] out_data2, out_data3;
    logic [1:0]  count2, count3;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    id_ex_elastic_reg #(.DATA_W(16), .DEPTH(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .in_data_i(in_data), .bubble_i(bubble), .hold_i(hold), .flush_i(flush),
        .out_valid_o(out_valid2), .out_ready_i(out_ready), .out_data_o(out_data2),
        .count_o(count2)
    );

    id_ex_elastic_reg #(.DATA_W(16), .DEPTH(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready3),
        .in_data_i(in_data), .bubble_i(bubble), .hold_i(hold), .flush_i(flush),
        .out_valid_o(out_valid3), .out_ready_i(out_ready), .out_data_o(out_data3),
        .count_o(count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: a FIFO queue per instance.
    logic [15:0] q2[$];
    logic [15:0] q3[$];
    bit          pu2, po2, pu3, po3;

    function automatic bit m_ready(input int sz, input int d);
        return !rst && (sz < d) && !hold && !bubble && !flush;
    endfunction

    always @(posedge clk) begin
        if (rst || flush) begin
            q2.delete();
            q3.delete();
        end else if (!hold) begin
            po2 = (q2.size() > 0) && out_ready;
            pu2 = in_valid && m_ready(q2.size(), 2);
            po3 = (q3.size() > 0) && out_ready;
            pu3 = in_valid && m_ready(q3.size(), 3);
            if (po2) void'(q2.pop_front());
            if (pu2) q2.push_back(in_data);
            if (po3) void'(q3.pop_front());
            if (pu3) q3.push_back(in_data);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("d2_valid", 32'(out_valid2), 32'(q2.size() != 0));
            chk("d2_data",  32'(out_data2),  (q2.size() != 0) ? 32'(q2[0]) : 32'd0);
            chk("d2_count", 32'(count2),     32'(q2.size()));
            chk("d2_ready", 32'(in_ready2),  32'(m_ready(q2.size(), 2)));
            chk("d3_valid", 32'(out_valid3), 32'(q3.size() != 0));
            chk("d3_data",  32'(out_data3),  (q3.size() != 0) ? 32'(q3[0]) : 32'd0);
            chk("d3_count", 32'(count3),     32'(q3.size()));
            chk("d3_ready", 32'(in_ready3),  32'(m_ready(q3.size(), 3)));
        end
    end

    task automatic drive(input bit v, input logic [15:0] d, input bit b, input bit h,
                         input bit f, input bit r, input bit ordy);
        in_valid  = v;
        in_data   = d;
        bubble    = b;
        hold      = h;
        flush     = f;
        rst       = r;
        out_ready = ordy;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int idle_cycles;

    initial begin
        // Reset with a valid producer
        drive(1, 16'h0055, 0, 0, 0, 1, 1);
        chk("rst_in_ready", 32'(in_ready2), 32'd0);
        step();
        chk_en = 1;
        step();
        chk("rst_count",  32'(count2),     32'd0);
        chk("rst_valid",  32'(out_valid2), 32'd0);
        chk("rst_data",   32'(out_data2),  32'd0);
        chk("rst_ready",  32'(in_ready2),  32'd0);
        drive(0, 16'h0000, 0, 0, 0, 0, 1);
        chk("post_rst_ready", 32'(in_ready2), 32'd1);

        // Streaming
        drive(1, 16'h00A1, 0, 0, 0, 0, 1); step();
        chk("stream_a1", 32'(out_data2), 32'h00A1);
        chk("stream_cnt1", 32'(count2), 32'd1);
        drive(1, 16'h00A2, 0, 0, 0, 0, 1); step();
        chk("stream_a2", 32'(out_data2), 32'h00A2);
        chk("stream_cnt2", 32'(count2), 32'd1);
        drive(1, 16'h00A3, 0, 0, 0, 0, 1); step();
        chk("stream_a3", 32'(out_data2), 32'h00A3);
        chk("stream_cnt3", 32'(count2), 32'd1);
        drive(0, 16'h0000, 0, 0, 0, 0, 1); step();
        chk("stream_empty", 32'(out_valid2), 32'd0);

        // Fill / drain
        drive(1, 16'h0011, 0, 0, 0, 0, 0); step();
        drive(1, 16'h0022, 0, 0, 0, 0, 0); step();
        drive(1, 16'h0033, 0, 0, 0, 0, 0);
        chk("full_ready", 32'(in_ready2), 32'd0);
        step();
        chk("full_count", 32'(count2), 32'd2);
        chk("full_head", 32'(out_data2), 32'h0011);
        chk("model_q3_fill", 32'(q3.size()), 32'd3);
        drive(0, 16'h0000, 0, 0, 0, 0, 1); step();
        chk("drain_22", 32'(out_data2), 32'h0022);
        step();
        chk("drain_valid", 32'(out_valid2), 32'd0);
        chk("drain_data",  32'(out_data2),  32'd0);
        step();
        chk("drain3_valid", 32'(out_valid3), 32'd0);

        // Flush overrides hold, incoming payload dropped
        drive(1, 16'h0044, 0, 0, 0, 0, 0); step();
        drive(1, 16'h0055, 0, 0, 0, 0, 0); step();
        chk("pre_flush_count", 32'(count2), 32'd2);
        drive(1, 16'h0066, 0, 1, 1, 0, 0);
        chk("flush_ready", 32'(in_ready2), 32'd0);
        step();
        chk("flush_count", 32'(count2), 32'd0);
        chk("flush_data",  32'(out_data2), 32'd0);
        chk("model_q2_flush", 32'(q2.size()), 32'd0);
        drive(0, 16'h0000, 0, 0, 0, 0, 0); step();
        chk("flush_absent", 32'(out_valid2), 32'd0);

        // Hold freezes state
        drive(1, 16'h0077, 0, 0, 0, 0, 0); step();
        drive(1, 16'h0088, 0, 1, 0, 0, 1);
        chk("hold_ready", 32'(in_ready2), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_data",  32'(out_data2), 32'h0077);
            chk("hold_count", 32'(count2),    32'd1);
        end
        drive(0, 16'h0000, 0, 0, 0, 0, 1); step();
        chk("hold_release", 32'(out_valid2), 32'd0);

        // Bubble and pointer wrap (pointers start mid-buffer here)
        idle_cycles = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1, 16'h00B0 + 16'(i), (i == 3), 0, 0, 0, 1);
            step();
            if (!out_valid3) idle_cycles++;
            chk("wrap_valid", 32'(out_valid3), 32'(i != 3));
            chk("wrap_data",  32'(out_data3),  (i == 3) ? 32'd0 : 32'h00B0 + 32'(i));
            chk("wrap_count", 32'(count3),     32'(i != 3));
        end
        chk("wrap_bubbles", 32'(idle_cycles), 32'd1);
        drive(0, 16'h0000, 0, 0, 0, 0, 1); step();
        chk("wrap_empty", 32'(out_valid3), 32'd0);

        @(negedge clk);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
